// File: rtl/acc_requant_fix8b.sv
// Accumulates signed 16-bit products into a saturating ACC_W-bit sum per group, then
// rounds, shifts and saturates the sum to signed 8 bits behind a valid/ready handshake.
module acc_requant_fix8b #(
  parameter int ACC_W   = 32,
  parameter int MAX_LEN = 1024,
  parameter int CNT_W   = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ivalid,
  output logic             oready,
  input  logic [15:0]      product,
  input  logic             ilast,
  input  logic [4:0]       frac_shift,
  output logic             ovalid,
  input  logic             iready,
  output logic [7:0]       result,
  output logic [ACC_W-1:0] sum_raw,
  output logic             ovf
);

  typedef enum logic [1:0] {S_ACC, S_RQ, S_OUT} state_t;

  // Requant math runs wide so the rounding add can never wrap, whatever the shift.
  localparam int RW = ACC_W + 32;
  localparam logic [ACC_W-1:0]     ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]     ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [RW-1:0] R_MAX   = RW'(127);
  localparam logic signed [RW-1:0] R_MIN   = RW'(-128);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       shift_q, shift_d;
  logic [7:0]       result_q, result_d;
  logic [ACC_W-1:0] sum_raw_q, sum_raw_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0]     base;
  logic [ACC_W:0]       sum_ext;
  logic                 acc_ovf;
  logic [ACC_W-1:0]     acc_sat;
  logic signed [RW-1:0] acc_wide, half, rsum, r;
  logic                 r_hi, r_lo;
  logic [7:0]           res8;

  always_comb begin
    // The first beat of a group restarts from zero instead of clearing acc on close.
    base     = (cnt_q == '0) ? '0 : acc_q;
    sum_ext  = {base[ACC_W-1], base} + {{(ACC_W-15){product[15]}}, product};
    acc_ovf  = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    acc_sat  = acc_ovf ? (sum_ext[ACC_W] ? ACC_MIN : ACC_MAX) : sum_ext[ACC_W-1:0];

    acc_wide = {{32{acc_q[ACC_W-1]}}, acc_q};
    half     = {{(RW-1){1'b0}}, 1'b1} << (shift_q - 5'd1);
    rsum     = acc_wide + half;
    r        = (shift_q == 5'd0) ? acc_wide : (rsum >>> shift_q);
    r_hi     = r > R_MAX;
    r_lo     = r < R_MIN;
    res8     = r_hi ? 8'h7f : (r_lo ? 8'h80 : r[7:0]);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    result_d  = result_q;
    sum_raw_d = sum_raw_q;
    ovf_d     = ovf_q;
    oready    = (state_q == S_ACC);
    ovalid    = (state_q == S_OUT);
    case (state_q)
      S_ACC: begin
        if (ivalid) begin
          acc_d = acc_sat;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == '0) shift_d = frac_shift;
          if (acc_ovf) ovf_d = 1'b1;
          if (ilast || cnt_q == CNT_W'(MAX_LEN - 1)) state_d = S_RQ;
        end
      end
      S_RQ: begin
        result_d  = res8;
        sum_raw_d = acc_q;
        ovf_d     = ovf_q | r_hi | r_lo;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (iready) begin
          state_d = S_ACC;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      result_q  <= '0;
      sum_raw_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      result_q  <= result_d;
      sum_raw_q <= sum_raw_d;
      ovf_q     <= ovf_d;
    end
  end

  assign result  = result_q;
  assign sum_raw = sum_raw_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_acc_requant_fix8b.sv
// Directed bench for acc_requant_fix8b: a 32-bit instance and a 17-bit instance share stimulus.
module tb_acc_requant_fix8b;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ivalid = 1'b0;
  logic        ilast = 1'b0;
  logic        iready = 1'b1;
  logic [15:0] product = '0;
  logic [4:0]  frac_shift = '0;

  logic        oready, ovalid, ovf;
  logic [7:0]  result;
  logic [31:0] sum_raw;
  logic        s_oready, s_ovalid, s_ovf;
  logic [7:0]  s_result;
  logic [16:0] s_sum_raw;

  int tests = 0;
  int fails = 0;

  acc_requant_fix8b #(.ACC_W(32), .MAX_LEN(8), .CNT_W(4)) u_dut (
    .clock(clock), .reset(reset), .ivalid(ivalid), .oready(oready), .product(product),
    .ilast(ilast), .frac_shift(frac_shift), .ovalid(ovalid), .iready(iready),
    .result(result), .sum_raw(sum_raw), .ovf(ovf)
  );

  acc_requant_fix8b #(.ACC_W(17), .MAX_LEN(8), .CNT_W(4)) u_sat (
    .clock(clock), .reset(reset), .ivalid(ivalid), .oready(s_oready), .product(product),
    .ilast(ilast), .frac_shift(frac_shift), .ovalid(s_ovalid), .iready(iready),
    .result(s_result), .sum_raw(s_sum_raw), .ovf(s_ovf)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input int p, input logic last, input logic [4:0] sh);
    ivalid     = 1'b1;
    product    = 16'(p);
    ilast      = last;
    frac_shift = sh;
    step();
    ivalid = 1'b0;
    ilast  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (ovalid !== 1'b0 || result !== 8'h00 || sum_raw !== 32'h0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: ovalid=%b result=%0d sum_raw=%0d ovf=%b, want 0/0/0/0",
               ovalid, result, sum_raw, ovf);
    end
    @(negedge clock);
    reset = 1'b0;
    step();
    tests++;
    if (oready !== 1'b1 || ovalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: oready=%b ovalid=%b, want 1/0", oready, ovalid);
    end
  endtask

  task automatic test_basic();
    iready = 1'b1;
    beat(3, 1'b0, 5'd0);
    beat(-5, 1'b0, 5'd0);
    beat(100, 1'b0, 5'd0);
    beat(2, 1'b1, 5'd0);
    tests++;
    if (ovalid !== 1'b0 || oready !== 1'b0) begin
      fails++;
      $display("FAIL basic_rq: ovalid=%b oready=%b, want 0/0", ovalid, oready);
    end
    step();
    tests++;
    if (ovalid !== 1'b1 || result !== 8'd100 || sum_raw !== 32'd100 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL basic_out: ovalid=%b result=%0d sum_raw=%0d ovf=%b, want 1/100/100/0",
               ovalid, $signed(result), $signed(sum_raw), ovf);
    end
    step();
    tests++;
    if (ovalid !== 1'b0 || oready !== 1'b1) begin
      fails++;
      $display("FAIL basic_taken: ovalid=%b oready=%b, want 0/1", ovalid, oready);
    end
  endtask

  task automatic test_saturate_requant();
    for (int i = 0; i < 8; i++) beat(16129, (i == 7), 5'd7);
    step();
    tests++;
    if (ovalid !== 1'b1 || result !== 8'd127 || sum_raw !== 32'd129032 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL sat_pos: ovalid=%b result=%0d sum_raw=%0d ovf=%b, want 1/127/129032/1",
               ovalid, $signed(result), $signed(sum_raw), ovf);
    end
    step();
    tests++;
    if (ovf !== 1'b0 || oready !== 1'b1) begin
      fails++;
      $display("FAIL sat_ovf_clear: ovf=%b oready=%b, want 0/1", ovf, oready);
    end
    // later beats carry a different shift that must be ignored
    beat(-16384, 1'b0, 5'd10);
    beat(-16384, 1'b0, 5'd0);
    beat(-16384, 1'b0, 5'd0);
    beat(-16384, 1'b1, 5'd0);
    step();
    tests++;
    if (result !== 8'(-64) || sum_raw !== 32'(-65536) || ovf !== 1'b0) begin
      fails++;
      $display("FAIL neg_shift10: result=%0d sum_raw=%0d ovf=%b, want -64/-65536/0",
               $signed(result), $signed(sum_raw), ovf);
    end
    step();
  endtask

  task automatic test_rounding();
    int prods[4] = '{6, 5, -6, -7};
    int exps[4]  = '{2, 1, -1, -2};
    for (int i = 0; i < 4; i++) begin
      beat(prods[i], 1'b1, 5'd2);
      step();
      tests++;
      if (ovalid !== 1'b1 || result !== 8'(exps[i])) begin
        fails++;
        $display("FAIL round_%0d: ovalid=%b result=%0d, want 1/%0d",
                 prods[i], ovalid, $signed(result), exps[i]);
      end
      step();
    end
  endtask

  task automatic test_max_len();
    iready = 1'b0;
    for (int i = 0; i < 7; i++) beat(1, 1'b0, 5'd0);
    tests++;
    if (oready !== 1'b1) begin
      fails++;
      $display("FAIL maxlen_early: oready=%b after 7 beats, want 1", oready);
    end
    beat(1, 1'b0, 5'd0);
    tests++;
    if (oready !== 1'b0 || ovalid !== 1'b0) begin
      fails++;
      $display("FAIL maxlen_rq: oready=%b ovalid=%b, want 0/0", oready, ovalid);
    end
    step();
    tests++;
    if (oready !== 1'b0 || ovalid !== 1'b1 || result !== 8'd8) begin
      fails++;
      $display("FAIL maxlen_out: oready=%b ovalid=%b result=%0d, want 0/1/8",
               oready, ovalid, $signed(result));
    end
    step();
    step();
    tests++;
    if (oready !== 1'b0 || ovalid !== 1'b1) begin
      fails++;
      $display("FAIL maxlen_hold: oready=%b ovalid=%b, want 0/1", oready, ovalid);
    end
    iready = 1'b1;
    step();
    tests++;
    if (oready !== 1'b1 || ovalid !== 1'b0) begin
      fails++;
      $display("FAIL maxlen_taken: oready=%b ovalid=%b, want 1/0", oready, ovalid);
    end
  endtask

  task automatic test_backpressure();
    iready = 1'b0;
    beat(40, 1'b1, 5'd0);
    step();
    ivalid  = 1'b1;
    product = 16'd50;
    ilast   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (ovalid !== 1'b1 || oready !== 1'b0 || result !== 8'd40 || sum_raw !== 32'd40) begin
        fails++;
        $display("FAIL stall_%0d: ovalid=%b oready=%b result=%0d sum_raw=%0d, want 1/0/40/40",
                 i, ovalid, oready, $signed(result), $signed(sum_raw));
      end
      step();
    end
    ivalid = 1'b0;
    ilast  = 1'b0;
    iready = 1'b1;
    step();
    tests++;
    if (ovalid !== 1'b0 || oready !== 1'b1) begin
      fails++;
      $display("FAIL stall_taken: ovalid=%b oready=%b, want 0/1", ovalid, oready);
    end
    beat(7, 1'b1, 5'd0);
    step();
    tests++;
    if (result !== 8'd7 || sum_raw !== 32'd7) begin
      fails++;
      $display("FAIL stall_next: result=%0d sum_raw=%0d, want 7/7", $signed(result), $signed(sum_raw));
    end
    step();
  endtask

  task automatic test_reset_midgroup();
    beat(1, 1'b0, 5'd0);
    beat(2, 1'b0, 5'd0);
    beat(3, 1'b0, 5'd0);
    #2 reset = 1'b1;
    #1;
    tests++;
    if (oready !== 1'b1 || ovalid !== 1'b0 || sum_raw !== 32'h0 || result !== 8'h0) begin
      fails++;
      $display("FAIL rst_mid: oready=%b ovalid=%b sum_raw=%0d result=%0d, want 1/0/0/0",
               oready, ovalid, sum_raw, result);
    end
    @(negedge clock);
    reset = 1'b0;
    step();
    beat(10, 1'b0, 5'd0);
    beat(20, 1'b1, 5'd0);
    step();
    tests++;
    if (ovalid !== 1'b1 || result !== 8'd30 || sum_raw !== 32'd30) begin
      fails++;
      $display("FAIL rst_regroup: ovalid=%b result=%0d sum_raw=%0d, want 1/30/30",
               ovalid, $signed(result), $signed(sum_raw));
    end
    iready = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    tests++;
    if (ovalid !== 1'b0 || oready !== 1'b1) begin
      fails++;
      $display("FAIL rst_out: ovalid=%b oready=%b, want 0/1", ovalid, oready);
    end
    @(negedge clock);
    reset  = 1'b0;
    iready = 1'b1;
    step();
  endtask

  task automatic test_acc_saturate();
    beat(32767, 1'b0, 5'd0);
    beat(32767, 1'b0, 5'd0);
    beat(32767, 1'b1, 5'd0);
    step();
    tests++;
    if (s_sum_raw !== 17'h0ffff || s_result !== 8'd127 || s_ovf !== 1'b1) begin
      fails++;
      $display("FAIL accsat_pos: sum_raw=%h result=%0d ovf=%b, want 0ffff/127/1",
               s_sum_raw, $signed(s_result), s_ovf);
    end
    tests++;
    if (sum_raw !== 32'd98301 || result !== 8'd127 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL wide_pos: sum_raw=%0d result=%0d ovf=%b, want 98301/127/1",
               $signed(sum_raw), $signed(result), ovf);
    end
    step();
    beat(-32768, 1'b0, 5'd0);
    beat(-32768, 1'b0, 5'd0);
    beat(-32768, 1'b1, 5'd0);
    step();
    tests++;
    if (s_sum_raw !== 17'h10000 || s_result !== 8'h80 || s_ovf !== 1'b1) begin
      fails++;
      $display("FAIL accsat_neg: sum_raw=%h result=%0d ovf=%b, want 10000/-128/1",
               s_sum_raw, $signed(s_result), s_ovf);
    end
    tests++;
    if (sum_raw !== 32'(-98304) || result !== 8'h80) begin
      fails++;
      $display("FAIL wide_neg: sum_raw=%0d result=%0d, want -98304/-128",
               $signed(sum_raw), $signed(result));
    end
    step();
    tests++;
    if (s_ovf !== 1'b0 || s_oready !== 1'b1 || s_ovalid !== 1'b0) begin
      fails++;
      $display("FAIL accsat_clear: ovf=%b oready=%b ovalid=%b, want 0/1/0", s_ovf, s_oready, s_ovalid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_saturate_requant();
    test_rounding();
    test_max_len();
    test_backpressure();
    test_reset_midgroup();
    test_acc_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
